// File: rtl/simple_processor_pkg.sv
// Shared widths and types for the simple processor pipeline.
package simple_processor_pkg;

    localparam int unsigned ADDR_WIDTH          = 32;
    localparam int unsigned DATA_WIDTH          = 32;
    localparam int unsigned REG_ADDR_WIDTH      = 5;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

    // Memory-access stage FSM states.
    typedef enum logic [0:0] {
        MEM_IDLE     = 1'b0,
        MEM_WAIT_ACK = 1'b1
    } mem_state_t;

endpackage : simple_processor_pkg

// File: rtl/mem_access_stage_timeout.sv
// Bounded-wait counter for the DMEM handshake; flags the last allowed wait cycle.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic arst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Count wait cycles without ack; expired is high during the TIMEOUT_CYCLES-th wait cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= (TIMEOUT_CYCLES == 1);
        end else if (enable) begin
            if (count != CNT_MAX) begin
                count <= count + CNT_W'(1);
            end
            expired <= ((count + CNT_W'(1)) == CNT_LAST);
        end
    end

endmodule : mem_timeout_counter

// File: rtl/mem_access_stage.sv
// Memory-access stage: DMEM req/ack handshake, EX stall, writeback beat and timeout.
module mem_access_stage
    import simple_processor_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = ADDR_WIDTH,
    parameter int unsigned MEM_DATA_WIDTH = DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      ex_valid_i,
    input  logic                      ex_load_i,
    input  logic                      ex_store_i,
    input  logic [MEM_ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [MEM_DATA_WIDTH-1:0] ex_wdata_i,
    input  logic [DATA_WIDTH-1:0]     ex_rd_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_rd_we_i,
    output logic                      stall_o,
    output logic                      dmem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic                      dmem_we_o,
    output logic [MEM_DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic [MEM_DATA_WIDTH-1:0] dmem_rdata_i,
    input  logic                      dmem_ack_i,
    output logic                      wb_valid_o,
    output logic                      wb_we_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_rd_data_o,
    output logic                      err_o
);

    mem_state_t state, state_d;

    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      we_q, we_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                      rd_we_q, rd_we_d;

    logic                      wb_valid_d;
    logic                      wb_we_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_d;
    logic [DATA_WIDTH-1:0]     wb_rd_data_d;
    logic                      err_d;

    logic                      cnt_clear;
    logic                      cnt_enable;
    logic                      expired;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_i),
        .arst   (arst_i),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expired(expired)
    );

    // Next-state, capture and writeback decode.
    always_comb begin
        state_d      = state;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        rd_addr_d    = rd_addr_q;
        rd_we_d      = rd_we_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = wb_we_o;
        wb_rd_addr_d = wb_rd_addr_o;
        wb_rd_data_d = wb_rd_data_o;
        err_d        = 1'b0;
        stall_o      = 1'b0;
        cnt_clear    = 1'b0;
        cnt_enable   = 1'b0;

        case (state)
            MEM_IDLE: begin
                if (ex_valid_i) begin
                    if (ex_load_i || ex_store_i) begin
                        // Load wins when both intents are set.
                        addr_d    = ex_addr_i;
                        wdata_d   = ex_wdata_i;
                        we_d      = ex_store_i && !ex_load_i;
                        rd_addr_d = ex_rd_addr_i;
                        rd_we_d   = ex_rd_we_i;
                        stall_o   = 1'b1;
                        cnt_clear = 1'b1;
                        state_d   = MEM_WAIT_ACK;
                    end else begin
                        wb_valid_d   = 1'b1;
                        wb_we_d      = ex_rd_we_i;
                        wb_rd_addr_d = ex_rd_addr_i;
                        wb_rd_data_d = ex_rd_data_i;
                    end
                end
            end
            MEM_WAIT_ACK: begin
                wb_rd_addr_d = rd_addr_q;
                if (dmem_ack_i) begin
                    state_d    = MEM_IDLE;
                    wb_valid_d = 1'b1;
                    if (we_q) begin
                        wb_we_d      = 1'b0;
                        wb_rd_data_d = '0;
                    end else begin
                        wb_we_d      = rd_we_q;
                        wb_rd_data_d = DATA_WIDTH'(dmem_rdata_i);
                    end
                end else begin
                    cnt_enable = 1'b1;
                    if (expired) begin
                        // Abort: release EX now, report the error with the beat.
                        state_d      = MEM_IDLE;
                        wb_valid_d   = 1'b1;
                        wb_we_d      = 1'b0;
                        wb_rd_data_d = '0;
                        err_d        = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Captured request and registered writeback outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_rd_addr_o <= '0;
            wb_rd_data_o <= '0;
            err_o        <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            rd_addr_q    <= rd_addr_d;
            rd_we_q      <= rd_we_d;
            wb_valid_o   <= wb_valid_d;
            wb_we_o      <= wb_we_d;
            wb_rd_addr_o <= wb_rd_addr_d;
            wb_rd_data_o <= wb_rd_data_d;
            err_o        <= err_d;
        end
    end

    assign dmem_req_o   = (state == MEM_WAIT_ACK);
    assign dmem_addr_o  = addr_q;
    assign dmem_we_o    = we_q;
    assign dmem_wdata_o = wdata_q;

endmodule : mem_access_stage
